// File: rtl/operand_fetch.sv
// operand_fetch: register file with same-cycle writeback bypass feeding a registered op1/op2 stage.
// Optional combinational debug read port is enabled by defining OPFETCH_DEBUG_PORT_EN.
module operand_fetch #(
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          rd_en_i,
  input  logic          stall_i,
  input  logic [AW-1:0] rs_i,
  input  logic [AW-1:0] rt_i,
  input  logic          imm_sel_i,
  input  logic [15:0]   imm_i,
  input  logic          imm_zext_i,
  input  logic          we_i,
  input  logic [AW-1:0] wa_i,
  input  logic [DW-1:0] wd_i,
  output logic [DW-1:0] op1_o,
  output logic [DW-1:0] op2_o,
`ifdef OPFETCH_DEBUG_PORT_EN
  input  logic [AW-1:0] dbg_addr_i,
  output logic [DW-1:0] dbg_data_o,
`endif
  output logic          op_valid_o
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_VALID = 1'b1
  } state_e;

  logic [DW-1:0] rf_q [NREGS];
  logic [DW-1:0] op1_q, op1_d;
  logic [DW-1:0] op2_q, op2_d;
  logic [DW-1:0] rs_val_s;
  logic [DW-1:0] rt_val_s;
  state_e        state_q;

  function automatic logic [DW-1:0] ext_imm(input logic [15:0] imm, input logic zext);
    return zext ? {{(DW-16){1'b0}}, imm} : {{(DW-16){imm[15]}}, imm};
  endfunction

  // Register file write port; entry 0 is never written so it stays zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREGS; i++) begin
        rf_q[i] <= '0;
      end
    end else if (we_i && (wa_i != '0)) begin
      rf_q[wa_i] <= wd_i;
    end
  end

  // Source reads with writeback bypass; address 0 reads zero and is never bypassed.
  always_comb begin
    rs_val_s = '0;
    rt_val_s = '0;
    if (rs_i == '0) begin
      rs_val_s = '0;
    end else if (we_i && (wa_i == rs_i)) begin
      rs_val_s = wd_i;
    end else begin
      rs_val_s = rf_q[rs_i];
    end
    if (rt_i == '0) begin
      rt_val_s = '0;
    end else if (we_i && (wa_i == rt_i)) begin
      rt_val_s = wd_i;
    end else begin
      rt_val_s = rf_q[rt_i];
    end
  end

  // Operand select: B is either the immediate or the bypassed register value.
  always_comb begin
    op1_d = rs_val_s;
    op2_d = rt_val_s;
    if (imm_sel_i) begin
      op2_d = ext_imm(imm_i, imm_zext_i);
    end else begin
      op2_d = rt_val_s;
    end
  end

  // Output pipeline register; stall freezes operands and the valid state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op1_q   <= '0;
      op2_q   <= '0;
      state_q <= ST_IDLE;
    end else if (!stall_i) begin
      case (state_q)
        ST_IDLE, ST_VALID: begin
          if (rd_en_i) begin
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            state_q <= ST_VALID;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign op1_o      = op1_q;
  assign op2_o      = op2_q;
  assign op_valid_o = (state_q == ST_VALID);

`ifdef OPFETCH_DEBUG_PORT_EN
  assign dbg_data_o = (dbg_addr_i == '0) ? '0 : rf_q[dbg_addr_i];
`endif

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Upstream stage of the integer ALU: 32x32 register file plus operand-select logic.
- Delivers registered op1/op2 to the ALU and holds them on stall.
- Accepts writeback of the ALU Result from the downstream stage.
- Register 0 is hardwired to zero; same-cycle writeback is forwarded into the fetched operands.

Parameters:
- NREGS, 32, number of architectural registers (power of two).
- AW, 5, register address width, log2(NREGS).
- DW, 32, data width; must match the ALU op1/op2 width.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_en  in  1  request operand fetch this cycle.
- stall  in  1  downstream not ready; hold outputs.
- rs  in  AW  source register A address (to op1).
- rt  in  AW  source register B address (to op2 when imm_sel=0).
- imm_sel  in  1  1 = op2 takes the extended immediate.
- imm  in  16  immediate field.
- imm_zext  in  1  1 = zero-extend imm, 0 = sign-extend.
- we  in  1  writeback enable.
- wa  in  AW  writeback address.
- wd  in  DW  writeback data (ALU Result).
- op1  out  DW  registered operand A.
- op2  out  DW  registered operand B.
- op_valid  out  1  op1/op2 hold a freshly fetched pair.

Behaviour:
- Reset: all registers, op1, op2 = 0; op_valid = 0. Reset overrides we, rd_en and stall in the same cycle.
- Write: on a rising edge with we=1 and wa!=0, reg[wa] <= wd. A write to wa=0 is silently dropped; reg[0] always reads 0.
- Writes are independent of stall and rd_en and are never blocked.
- Fetch latency is 1 cycle. If rd_en=1 and stall=0 at edge N, then after edge N op1/op2 hold the values selected at N and op_valid=1.
- Operand A = (rs==0) ? 0 : (we && wa==rs ? wd : reg[rs]).
- Operand B when imm_sel=0: same rule using rt.
- Operand B when imm_sel=1: imm_zext ? {16'b0,imm} : {{16{imm[15]}},imm}. Register B and the bypass are ignored.
- Bypass: a same-cycle write to the address being read delivers the new wd, not the stale value.
- Bypass never applies to address 0, even if we=1 and wa=0.
- stall=1: op1, op2 and op_valid hold unchanged regardless of rd_en. A write still updates the file. A held operand is not refreshed by a later write to its source register.
- rd_en=0 and stall=0: op_valid <= 0; op1/op2 hold their last values.
- Reset mid-operation: a pending fetch is discarded; op_valid=0 on the next cycle.
- Arithmetic: no arithmetic here; width fixed at DW. Immediate extension is the only data transform.
- States are per-register storage plus the output pipeline register (IDLE when op_valid=0, VALID when op_valid=1). Transitions:
  - IDLE->VALID on rd_en & ~stall.
  - VALID->VALID on rd_en & ~stall, or on stall.
  - VALID->IDLE on ~rd_en & ~stall.

Optional Feature:
- Macro: OPFETCH_DEBUG_PORT_EN.
- Defined: adds input dbg_addr (AW) and output dbg_data (DW), an asynchronous combinational read of reg[dbg_addr].
  - No bypass on this port; address 0 reads 0.
  - Used by testbenches and a board display.
- Undefined: neither port exists; no extra logic.

Test Plan:
- Reset with rst=1 for 2 cycles, then rd_en=1, rs=3, rt=7, imm_sel=0 -> next cycle op1=0, op2=0, op_valid=1.
- Write we=1, wa=5, wd=0x0000_00A5. Next cycle rd_en=1, rs=5, rt=0 -> op1=0x0000_00A5, op2=0.
- Same-cycle bypass: reg[9]=0x1111_1111; we=1, wa=9, wd=0xDEAD_BEEF with rd_en=1, rs=9 -> op1=0xDEAD_BEEF. Then reg[9] reads 0xDEAD_BEEF.
- Write to zero: we=1, wa=0, wd=0xFFFF_FFFF with rd_en=1, rs=0 -> op1=0. A later read of rs=0 still gives 0.
- Immediate: imm_sel=1, imm=0x8001.
  - imm_zext=0 -> op2=0xFFFF_8001.
  - imm_zext=1 -> op2=0x0000_8001.
- Stall: fetch rs=5 (op1=0xA5). Assert stall=1 for 3 cycles with rd_en=1, rs=9 and we=1, wa=5, wd=0x77.
  - During stall: op1 stays 0xA5, op_valid stays 1.
  - After release, a fetch of rs=5 -> op1=0x77.
